// File: rtl/apb_master_bridge.sv
// APB3 initiator bridge: turns one valid/ready request into a SETUP->ACCESS
// transfer and returns the outcome through a one-entry response register.
// Only one transfer is ever in flight. A programmable PREADY timeout aborts
// hung slaves with an error response.
//
// Handshake rule (request and response sides alike): a beat transfers on a
// rising edge where valid and ready are both 1. Once valid is raised, the
// payload is held stable until that edge. No ready depends combinationally
// on the matching valid.
module apb_master_bridge #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic                      req_write_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i,
   output logic [1:0]                dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // A zero timeout still needs a legal (1-bit) counter; it is simply never compared.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [CNT_W-1:0] to_cnt;
   logic             to_hit;

   assign dbg_state_o = state;

   // The current stalled ACCESS cycle is the one that brings the count up to the limit.
   always_comb begin
      to_hit = 1'b0;
      if (TIMEOUT_CYCLES > 0) begin
         to_hit = ((int'(to_cnt) + 1) >= TIMEOUT_CYCLES);
      end
   end

   // Transfer sequencer; every APB and response output is a register written here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         to_cnt      <= '0;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         paddr_o     <= '0;
         pwdata_o    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  // The APB address/control registers double as the request latch.
                  paddr_o     <= req_addr_i;
                  pwrite_o    <= req_write_i;
                  pwdata_o    <= req_wdata_i;
                  psel_o      <= 1'b1;
                  penable_o   <= 1'b0;
                  req_ready_o <= 1'b0;
                  to_cnt      <= '0;
                  state       <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_o <= 1'b1;
               state     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (pready_i) begin
                  // A slave answering on the very cycle the limit is hit still completes normally.
                  rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                  rsp_err_o   <= pslverr_i;
                  rsp_valid_o <= 1'b1;
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  state       <= ST_RESP;
               end else if (to_hit) begin
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  state       <= ST_RESP;
               end else if (to_cnt != CNT_MAX) begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_apb_master_bridge;

   logic        clk;
   logic        rst;
   int          n_tests;
   int          n_fail;

   // Instance with a short timeout (dut4)
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] paddr, pwdata, prdata;
   logic [1:0]  dbg_state;

   // Instance with timeout disabled (dut0)
   logic        req_valid_z, req_ready_z, req_write_z;
   logic [31:0] req_addr_z, req_wdata_z;
   logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [31:0] rsp_rdata_z;
   logic        psel_z, penable_z, pwrite_z, pready_z, pslverr_z;
   logic [31:0] paddr_z, pwdata_z, prdata_z;
   logic [1:0]  dbg_state_z;

   apb_master_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut4 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_write_i(req_write), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr), .dbg_state_o(dbg_state)
   );

   apb_master_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid_z), .req_ready_o(req_ready_z), .req_addr_i(req_addr_z),
      .req_write_i(req_write_z), .req_wdata_i(req_wdata_z),
      .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z), .rsp_rdata_o(rsp_rdata_z), .rsp_err_o(rsp_err_z),
      .psel_o(psel_z), .penable_o(penable_z), .pwrite_o(pwrite_z), .paddr_o(paddr_z), .pwdata_o(pwdata_z),
      .prdata_i(prdata_z), .pready_i(pready_z), .pslverr_i(pslverr_z), .dbg_state_o(dbg_state_z)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Presents one request while dut4 is idle; returns at the SETUP-cycle sample point.
   task automatic start_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      req_wdata = wd;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      int setups;
      int readys;
      int bad;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0; rsp_ready = 0;
      prdata = 0; pready = 0; pslverr = 0;
      req_valid_z = 0; req_addr_z = 0; req_write_z = 0; req_wdata_z = 0; rsp_ready_z = 0;
      prdata_z = 0; pready_z = 0; pslverr_z = 0;
      repeat (2) step();

      // Reset state
      check_eq("rst_req_ready", req_ready, 1);
      check_eq("rst_psel", psel, 0);
      check_eq("rst_penable", penable, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_paddr", paddr, 0);
      check_eq("rst_pwdata", pwdata, 0);
      check_eq("rst_state", dbg_state, 0);
      rst = 1'b0;
      step();

      // 1: zero-wait write
      pready = 1'b1; rsp_ready = 1'b1;
      start_req(32'h1000, 1'b1, 32'hDEADBEEF);
      check_eq("t1_setup_psel", psel, 1);
      check_eq("t1_setup_penable", penable, 0);
      check_eq("t1_setup_ready", req_ready, 0);
      check_eq("t1_paddr", paddr, 32'h1000);
      check_eq("t1_pwdata", pwdata, 32'hDEADBEEF);
      check_eq("t1_pwrite", pwrite, 1);
      check_eq("t1_rsp_early", rsp_valid, 0);
      step();
      check_eq("t1_access_penable", penable, 1);
      check_eq("t1_access_psel", psel, 1);
      step();
      check_eq("t1_rsp_valid", rsp_valid, 1);
      check_eq("t1_rsp_err", rsp_err, 0);
      check_eq("t1_rsp_rdata", rsp_rdata, 0);
      check_eq("t1_psel_drop", psel, 0);
      step();
      check_eq("t1_idle_rsp", rsp_valid, 0);
      check_eq("t1_idle_ready", req_ready, 1);
      check_eq("t1_hold_paddr", paddr, 32'h1000);

      // 2: read with 3 wait states and a slave error
      pready = 1'b0; prdata = 32'h12345678; pslverr = 1'b1;
      start_req(32'h2004, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t2_access_psel", psel, 1);
         check_eq("t2_access_penable", penable, 1);
         check_eq("t2_access_paddr", paddr, 32'h2004);
         check_eq("t2_access_rsp", rsp_valid, 0);
         if (i == 3) pready = 1'b1;
      end
      step();
      check_eq("t2_rsp_valid", rsp_valid, 1);
      check_eq("t2_rsp_rdata", rsp_rdata, 32'h12345678);
      check_eq("t2_rsp_err", rsp_err, 1);
      check_eq("t2_pwrite", pwrite, 0);
      step();

      // 3a: stuck slave, abort after exactly 4 ACCESS cycles
      pready = 1'b0; pslverr = 1'b0; prdata = 32'hCAFEF00D;
      start_req(32'h3000, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t3a_access_psel", psel, 1);
         check_eq("t3a_access_penable", penable, 1);
      end
      step();
      check_eq("t3a_psel_drop", psel, 0);
      check_eq("t3a_penable_drop", penable, 0);
      check_eq("t3a_rsp_valid", rsp_valid, 1);
      check_eq("t3a_rsp_err", rsp_err, 1);
      check_eq("t3a_rsp_rdata", rsp_rdata, 0);
      step();

      // 3b: slave answers on the 4th cycle, the limit cycle -> normal completion
      pready = 1'b0; pslverr = 1'b0; prdata = 32'hA5A5A5A5;
      start_req(32'h3004, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t3b_access_psel", psel, 1);
         if (i == 3) pready = 1'b1;
      end
      step();
      check_eq("t3b_rsp_valid", rsp_valid, 1);
      check_eq("t3b_rsp_err", rsp_err, 0);
      check_eq("t3b_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
      step();

      // 4: back-to-back reads, one transfer every 4 cycles
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h00C0FFEE; rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h5000; req_write = 1'b0;
      setups = 0;
      readys = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (psel && !penable) setups++;
         if (req_ready) readys++;
         if (i == 0 || i == 4 || i == 8) check_eq("t4_setup_slot", psel && !penable, 1);
         if (i == 2) check_eq("t4_rsp_rdata", rsp_rdata, 32'h00C0FFEE);
      end
      check_eq("t4_setup_count", setups, 3);
      check_eq("t4_ready_count", readys, 3);
      // Response back-pressure: held for 5 cycles, no new SETUP
      rsp_ready = 1'b0; prdata = 32'h0BADF00D;
      repeat (3) step();
      check_eq("t4_bp_rsp_valid", rsp_valid, 1);
      check_eq("t4_bp_rsp_rdata", rsp_rdata, 32'h0BADF00D);
      prdata = 32'hFFFF0000;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("t4_bp_hold_valid", rsp_valid, 1);
         check_eq("t4_bp_hold_rdata", rsp_rdata, 32'h0BADF00D);
         check_eq("t4_bp_no_setup", psel, 0);
         check_eq("t4_bp_not_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      step();
      check_eq("t4_consumed_valid", rsp_valid, 0);
      check_eq("t4_consumed_ready", req_ready, 1);
      req_valid = 1'b0;
      step();
      check_eq("t4_idle_psel", psel, 0);

      // 5: reset in the middle of ACCESS
      pready = 1'b0;
      start_req(32'h6000, 1'b1, 32'h11112222);
      step();
      check_eq("t5_in_access", penable, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_async_psel", psel, 0);
      check_eq("t5_async_penable", penable, 0);
      check_eq("t5_async_rsp", rsp_valid, 0);
      check_eq("t5_async_ready", req_ready, 1);
      step();
      rst = 1'b0;
      pready = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid || psel) bad++;
      end
      check_eq("t5_no_response", bad, 0);
      check_eq("t5_paddr_cleared", paddr, 0);

      // 6: timeout disabled, 1000 stalled cycles then completion
      pready_z = 1'b0; pslverr_z = 1'b0; prdata_z = 32'h600DCAFE; rsp_ready_z = 1'b1;
      req_valid_z = 1'b1; req_addr_z = 32'h7000; req_write_z = 1'b0;
      step();
      req_valid_z = 1'b0;
      check_eq("t6_setup", psel_z && !penable_z, 1);
      bad = 0;
      for (int i = 0; i < 1001; i++) begin
         step();
         if (!(psel_z && penable_z) || rsp_valid_z) bad++;
         if (i == 1000) pready_z = 1'b1;
      end
      check_eq("t6_no_abort", bad, 0);
      step();
      check_eq("t6_rsp_valid", rsp_valid_z, 1);
      check_eq("t6_rsp_err", rsp_err_z, 0);
      check_eq("t6_rsp_rdata", rsp_rdata_z, 32'h600DCAFE);
      step();
      check_eq("t6_idle", req_ready_z, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
